bus_rtc: RTL and testbench
==========================

# bus_rtc

Bus-cycle generator for the external RTC's multiplexed address/data port. It sits directly downstream of the RTC read/write control FSM, which presents `activa`, `w`, `dir` and write data. `bus_rtc` runs one complete address-phase plus data-phase cycle on the chip pins (`cs_n`, `rd_n`, `wr_n`, `a_d`, `ad`), latches read data, and returns a one-cycle `fin` that the control FSM uses to leave its transfer state.

## Interface

Parameters:
- `T_SU`, default 2: setup cycles per phase; legal 1..15.
- `T_PW`, default 4: strobe-low cycles per phase; legal 1..15.
- `T_H`, default 2: hold cycles per phase; legal 1..15.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `activa`  in  1  request a bus cycle; level, sampled only in ESPERA.
- `w`  in  1  1 = write to RTC, 0 = read.
- `dir`  in  8  RTC register address.
- `dato_in`  in  8  write data.
- `ad_in`  in  8  pad input from the shared AD bus.
- `ad_out`  out  8  pad output to the AD bus.
- `ad_oe`  out  1  pad output enable; 1 = FPGA drives AD.
- `cs_n`, `rd_n`, `wr_n`  out  1 each  chip select, read strobe and write strobe, all active-low.
- `a_d`  out  1  0 = address phase, 1 = data phase.
- `dato_out`  out  8  last byte read from the RTC.
- `fin`  out  1  one-cycle pulse marking end of cycle.
- `ocupado`  out  1  high in every state except ESPERA.

## Operation

- All outputs are registered and are functions of the current state, so they are glitch-free.
- Reset value of every output:
  - `cs_n`, `rd_n`, `wr_n`, `a_d` = 1.
  - `ad_oe`, `ad_out`, `dato_out`, `fin`, `ocupado` = 0.
  - State is ESPERA and the phase counter is 0.
- Reset is asynchronous and may assert mid-cycle. It aborts the cycle immediately and returns all outputs to reset values; no `fin` is produced.
- States and transitions:
  - ESPERA: if `activa`=1, latch `w`, `dir`, `dato_in` into internal registers and go to DIR_SU.
  - DIR_SU (`T_SU` cycles): `cs_n`=0, `a_d`=0, `ad_oe`=1, `ad_out`=latched `dir`.
  - DIR_PW (`T_PW` cycles): as DIR_SU, plus `wr_n`=0. The address is always strobed with `wr_n`.
  - DIR_H (`T_H` cycles): `wr_n`=1; address is still driven.
  - DAT_SU (`T_SU` cycles): `a_d`=1.
    - Write: `ad_out`=latched data, `ad_oe`=1.
    - Read: `ad_oe`=0. This phase doubles as the bus turnaround.
  - DAT_PW (`T_PW` cycles): `wr_n`=0 for a write, or `rd_n`=0 for a read.
  - DAT_H (`T_H` cycles): both strobes high; `cs_n` stays 0.
  - FIN (1 cycle): `fin`=1, `cs_n`=1, `ad_oe`=0, `ad_out`=0.
  - ESPERA_BAJA: wait for `activa`=0, then go to ESPERA.
- ESPERA_BAJA exists because the upstream FSM holds `activa` high for up to 2 cycles after `fin`. It prevents a second, unrequested bus cycle.
- Read capture: `dato_out` is loaded from `ad_in` at the clock edge that ends the last DAT_PW cycle, i.e. coincident with `rd_n` rising.
  - `dato_out` is unchanged by write cycles and holds until the next read.
- Inputs are ignored from the latch point onward:
  - Changes on `w`, `dir`, `dato_in` mid-cycle have no effect.
  - A drop of `activa` mid-cycle has no effect. The cycle always completes and `fin` still pulses; ESPERA_BAJA then exits on the next cycle.
- Phase counter:
  - 4-bit, cleared on every state change, and increments while the state holds.
  - A phase exits when the counter equals its parameter minus 1.
- `rd_n` and `wr_n` are never low in the same cycle.
- `ad_oe`=1 and `rd_n`=0 never occur together.

## Timing

- Let `activa` be sampled high at edge k in ESPERA.
- With defaults (2/4/2):
  - DIR_SU: cycles k+1..k+2.
  - DIR_PW: cycles k+3..k+6.
  - DIR_H: cycles k+7..k+8.
  - DAT_SU: cycles k+9..k+10.
  - DAT_PW: cycles k+11..k+14.
  - DAT_H: cycles k+15..k+16.
  - FIN: cycle k+17.
- General latency: `activa` sampled to `fin` = 2·(`T_SU`+`T_PW`+`T_H`)+1 cycles.
- `cs_n` is low for exactly 2·(`T_SU`+`T_PW`+`T_H`) cycles.
- Minimum spacing between two `fin` pulses is latency + 2 cycles: FIN, then ESPERA_BAJA for at least 1 cycle, then ESPERA.

## Test plan

- Reset: hold `reset`=0 with random inputs.
  - Outputs at reset values; `activa`=1 is ignored until `reset`=1.
- Write, defaults: `w`=1, `dir`=8'h0A, `dato_in`=8'h5C, `activa` pulsed at edge k.
  - `ad_out`=0A with `a_d`=0 and `wr_n` low in k+3..k+6.
  - `ad_out`=5C with `a_d`=1 and `wr_n` low in k+11..k+14.
  - `fin`=1 only in k+17.
- Read: `w`=0, `dir`=8'h04, model drives `ad_in`=8'hA7 while `rd_n`=0.
  - `ad_oe`=0 from k+9 onward.
  - `dato_out`=A7 from k+15.
  - No cycle with both `ad_oe`=1 and `rd_n`=0.
- Upstream handshake: `activa` held high 2 cycles past `fin`, then driven low.
  - Exactly one `cs_n` assertion.
  - Next request accepted only after `activa` returns low.
- Mid-cycle disturbance: change `dir`/`w` and drop `activa` at k+5.
  - Cycle completes unchanged and `fin` still pulses at k+17.
- Reset mid-cycle: assert `reset` at k+12 during DAT_PW.
  - Outputs return to reset values asynchronously, before the next edge.
  - No `fin`; `dato_out` remains 0.

Source files
------------

// File: rtl/bus_rtc.sv
// Bus-cycle generator for the RTC multiplexed AD port: one address phase plus one data phase per request.
// Latency activa->fin is 2*(T_SU+T_PW+T_H)+1 cycles; all pins are registered decodes of the next state.
module bus_rtc #(
    parameter int T_SU = 2,
    parameter int T_PW = 4,
    parameter int T_H  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       activa,
    input  logic       w,
    input  logic [7:0] dir,
    input  logic [7:0] dato_in,
    input  logic [7:0] ad_in,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic       a_d,
    output logic [7:0] dato_out,
    output logic       fin,
    output logic       ocupado
);

    typedef enum logic [3:0] {
        ESPERA, DIR_SU, DIR_PW, DIR_H, DAT_SU, DAT_PW, DAT_H, FIN, ESPERA_BAJA
    } state_t;

    localparam logic [3:0] C_SU = 4'(T_SU - 1);
    localparam logic [3:0] C_PW = 4'(T_PW - 1);
    localparam logic [3:0] C_H  = 4'(T_H - 1);

    state_t     r_state, w_state_nxt;
    logic [3:0] r_cnt;
    logic       r_w, w_w_nxt;
    logic [7:0] r_dir, w_dir_nxt;
    logic [7:0] r_dat, w_dat_nxt;
    logic       w_capture;

    logic [7:0] r_ad_out, w_ad_out;
    logic       r_ad_oe, w_ad_oe;
    logic       r_cs_n, w_cs_n;
    logic       r_rd_n, w_rd_n;
    logic       r_wr_n, w_wr_n;
    logic       r_a_d, w_a_d;
    logic [7:0] r_dato_out;
    logic       r_fin, w_fin;
    logic       r_ocupado, w_ocupado;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ESPERA;
            r_cnt      <= 4'd0;
            r_w        <= 1'b0;
            r_dir      <= 8'h00;
            r_dat      <= 8'h00;
            r_ad_out   <= 8'h00;
            r_ad_oe    <= 1'b0;
            r_cs_n     <= 1'b1;
            r_rd_n     <= 1'b1;
            r_wr_n     <= 1'b1;
            r_a_d      <= 1'b1;
            r_dato_out <= 8'h00;
            r_fin      <= 1'b0;
            r_ocupado  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= (w_state_nxt != r_state) ? 4'd0 : r_cnt + 4'd1;
            r_w       <= w_w_nxt;
            r_dir     <= w_dir_nxt;
            r_dat     <= w_dat_nxt;
            r_ad_out  <= w_ad_out;
            r_ad_oe   <= w_ad_oe;
            r_cs_n    <= w_cs_n;
            r_rd_n    <= w_rd_n;
            r_wr_n    <= w_wr_n;
            r_a_d     <= w_a_d;
            r_fin     <= w_fin;
            r_ocupado <= w_ocupado;
            if (w_capture) begin
                r_dato_out <= ad_in;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_w_nxt     = r_w;
        w_dir_nxt   = r_dir;
        w_dat_nxt   = r_dat;
        case (r_state)
            ESPERA: begin
                if (activa) begin
                    w_state_nxt = DIR_SU;
                    w_w_nxt     = w;
                    w_dir_nxt   = dir;
                    w_dat_nxt   = dato_in;
                end
            end
            DIR_SU:      if (r_cnt == C_SU) w_state_nxt = DIR_PW;
            DIR_PW:      if (r_cnt == C_PW) w_state_nxt = DIR_H;
            DIR_H:       if (r_cnt == C_H)  w_state_nxt = DAT_SU;
            DAT_SU:      if (r_cnt == C_SU) w_state_nxt = DAT_PW;
            DAT_PW:      if (r_cnt == C_PW) w_state_nxt = DAT_H;
            DAT_H:       if (r_cnt == C_H)  w_state_nxt = FIN;
            FIN:         w_state_nxt = ESPERA_BAJA;
            // Upstream keeps activa high briefly after fin; wait it out.
            ESPERA_BAJA: if (!activa) w_state_nxt = ESPERA;
            default:     w_state_nxt = ESPERA;
        endcase

        // Read data is sampled on the edge that raises rd_n.
        w_capture = (r_state == DAT_PW) && !r_w && (r_cnt == C_PW);

        w_ad_out  = 8'h00;
        w_ad_oe   = 1'b0;
        w_cs_n    = 1'b1;
        w_rd_n    = 1'b1;
        w_wr_n    = 1'b1;
        w_a_d     = 1'b1;
        w_fin     = 1'b0;
        w_ocupado = (w_state_nxt != ESPERA);
        case (w_state_nxt)
            DIR_SU, DIR_PW, DIR_H: begin
                w_cs_n   = 1'b0;
                w_a_d    = 1'b0;
                w_ad_oe  = 1'b1;
                w_ad_out = w_dir_nxt;
                w_wr_n   = (w_state_nxt != DIR_PW);
            end
            DAT_SU, DAT_PW, DAT_H: begin
                w_cs_n   = 1'b0;
                w_ad_oe  = w_w_nxt;
                w_ad_out = w_w_nxt ? w_dat_nxt : 8'h00;
                if (w_state_nxt == DAT_PW) begin
                    w_wr_n = !w_w_nxt;
                    w_rd_n = w_w_nxt;
                end
            end
            FIN:     w_fin = 1'b1;
            default: ;
        endcase
    end

    assign ad_out   = r_ad_out;
    assign ad_oe    = r_ad_oe;
    assign cs_n     = r_cs_n;
    assign rd_n     = r_rd_n;
    assign wr_n     = r_wr_n;
    assign a_d      = r_a_d;
    assign dato_out = r_dato_out;
    assign fin      = r_fin;
    assign ocupado  = r_ocupado;

endmodule

// File: tb/tb_bus_rtc.sv
// Scoreboard bench for bus_rtc: stimulus queues expected bus cycles, a negedge monitor checks each on fin.
module tb_bus_rtc;

    logic       clk = 1'b0;
    logic       reset;
    logic       activa;
    logic       w;
    logic [7:0] dir;
    logic [7:0] dato_in;
    logic [7:0] ad_in;
    logic [7:0] ad_out;
    logic       ad_oe;
    logic       cs_n, rd_n, wr_n, a_d;
    logic [7:0] dato_out;
    logic       fin;
    logic       ocupado;
    logic [7:0] rd_model;

    always #5 clk = ~clk;

    // RTC model: drives the AD bus only while rd_n is low.
    assign ad_in = rd_n ? 8'h00 : rd_model;

    bus_rtc #(.T_SU(2), .T_PW(4), .T_H(2)) dut (
        .clk(clk), .reset(reset), .activa(activa), .w(w), .dir(dir),
        .dato_in(dato_in), .ad_in(ad_in), .ad_out(ad_out), .ad_oe(ad_oe),
        .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .a_d(a_d),
        .dato_out(dato_out), .fin(fin), .ocupado(ocupado)
    );

    typedef struct {
        int         fin_cyc;
        logic       w;
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] dout;
    } exp_t;

    exp_t sbq[$];
    int   passed = 0;
    int   total  = 0;
    int   cyc    = 0;
    logic [7:0] last_read = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Monitor state
    int   viol = 0, fin_cnt = 0, cs_falls = 0;
    int   cs_low, addr_cyc, dstb_cyc, wr_cnt, rd_cnt;
    logic [7:0] obs_addr, obs_data, rise_dout;
    logic su_seen, su_oe;
    logic prev_cs = 1'b1, prev_rd = 1'b1;

    always @(negedge clk) begin
        exp_t e;
        if ((!rd_n && !wr_n) || (ad_oe && !rd_n)) viol++;
        if (prev_cs && !cs_n) begin
            cs_falls++;
            cs_low = 0; addr_cyc = -1; dstb_cyc = -1; wr_cnt = 0; rd_cnt = 0;
            su_seen = 1'b0; su_oe = 1'b0; obs_addr = 8'h00; obs_data = 8'h00; rise_dout = 8'h00;
        end
        if (!cs_n) cs_low++;
        if (!cs_n && !a_d && !wr_n) begin
            if (addr_cyc < 0) begin addr_cyc = cyc; obs_addr = ad_out; end
            wr_cnt++;
        end
        if (!cs_n && a_d && !su_seen) begin su_seen = 1'b1; su_oe = ad_oe; end
        if (!cs_n && a_d && (!wr_n || !rd_n) && dstb_cyc < 0) dstb_cyc = cyc;
        if (!cs_n && a_d && !wr_n) begin obs_data = ad_out; wr_cnt++; end
        if (!rd_n) rd_cnt++;
        if (!prev_rd && rd_n) rise_dout = dato_out;
        if (fin) begin
            fin_cnt++;
            if (sbq.size() == 0) begin
                chk("unexpected_fin", sbq.size(), 1);
            end else begin
                e = sbq.pop_front();
                chk("fin_cycle",   cyc,      e.fin_cyc);
                chk("cs_low_len",  cs_low,   16);
                chk("addr_byte",   obs_addr, e.addr);
                chk("addr_strobe", addr_cyc, e.fin_cyc - 14);
                chk("data_strobe", dstb_cyc, e.fin_cyc - 6);
                chk("dat_su_oe",   su_oe,    e.w);
                chk("wr_cycles",   wr_cnt,   e.w ? 8 : 4);
                chk("rd_cycles",   rd_cnt,   e.w ? 0 : 4);
                if (e.w) chk("write_data", obs_data, e.data);
                else     chk("dout_at_rd_rise", rise_dout, e.dout);
                chk("dato_out", dato_out, e.dout);
            end
        end
        prev_cs = cs_n;
        prev_rd = rd_n;
    end

    task automatic issue(input logic wi, input logic [7:0] d, input logic [7:0] di, input logic [7:0] rv);
        exp_t e;
        @(negedge clk);
        w = wi; dir = d; dato_in = di; rd_model = rv; activa = 1'b1;
        if (!wi) last_read = rv;
        e.fin_cyc = cyc + 17;
        e.w = wi; e.addr = d; e.data = di; e.dout = last_read;
        sbq.push_back(e);
    endtask

    task automatic chk_idle(input string nm);
        chk(nm, {cs_n, rd_n, wr_n, a_d, ad_oe, fin, ocupado, ad_out, dato_out},
            {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00});
    endtask

    initial begin
        int base_falls, base_fins;
        reset = 1'b0; activa = 1'b0; w = 1'b0; dir = 8'h00; dato_in = 8'h00; rd_model = 8'h00;

        // Reset held with random inputs and activa asserted
        repeat (4) begin
            @(negedge clk);
            activa = 1'b1; w = 1'($urandom); dir = 8'($urandom); dato_in = 8'($urandom);
        end
        #1 chk_idle("reset_values");
        @(negedge clk);
        activa = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk_idle("idle_after_reset");

        // Write with defaults, single-cycle pulse
        issue(1'b1, 8'h0A, 8'h5C, 8'h00);
        @(negedge clk) activa = 1'b0;
        repeat (22) @(negedge clk);

        // Read
        issue(1'b0, 8'h04, 8'h00, 8'hA7);
        @(negedge clk) activa = 1'b0;
        repeat (22) @(negedge clk);
        chk("dato_out_held", dato_out, 8'hA7);

        // Upstream handshake: activa stays high 2 cycles past fin
        base_falls = cs_falls;
        issue(1'b1, 8'h33, 8'h44, 8'h00);
        repeat (19) @(negedge clk);
        chk("ocupado_in_espera_baja", ocupado, 1'b1);
        activa = 1'b0;
        repeat (10) @(negedge clk);
        chk("single_cs_assertion", cs_falls - base_falls, 1);
        chk("ocupado_back_low", ocupado, 1'b0);

        // Mid-cycle disturbance on inputs and activa
        issue(1'b1, 8'h11, 8'h22, 8'h00);
        repeat (5) @(negedge clk);
        w = 1'b0; dir = 8'hFF; dato_in = 8'h00; activa = 1'b0;
        repeat (20) @(negedge clk);

        // Reset in DAT_PW of a read: no fin, no capture
        base_fins = fin_cnt;
        begin
            exp_t dummy;
            issue(1'b0, 8'h04, 8'h00, 8'h99);
            dummy = sbq.pop_back();
            last_read = 8'h00;
        end
        @(negedge clk) activa = 1'b0;
        repeat (11) @(negedge clk);
        chk("rd_low_before_reset", rd_n, 1'b0);
        #2 reset = 1'b0;
        #1 chk_idle("async_reset_midcycle");
        @(negedge clk);
        reset = 1'b1;
        repeat (25) @(negedge clk);
        chk("no_fin_after_abort", fin_cnt - base_fins, 0);
        chk("dato_out_after_abort", dato_out, 8'h00);

        // Recovery read
        issue(1'b0, 8'h3C, 8'h00, 8'h5A);
        @(negedge clk) activa = 1'b0;
        repeat (22) @(negedge clk);

        for (int i = 0; i < 100 && sbq.size() != 0; i++) @(negedge clk);
        chk("queue_drained", sbq.size(), 0);
        chk("protocol_violations", viol, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
